// File: rtl/mem_stage_transpose_pp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_transpose_pp_pkg
//  Purpose  : Shared definitions for the streaming transpose/pass-through
//             stage: block mode encodings and the per-phase control states.
//  Revision : 1.0  initial release
// ============================================================================
package mem_stage_transpose_pp_pkg;

    localparam logic c_MODE_PASS      = 1'b0;
    localparam logic c_MODE_TRANSPOSE = 1'b1;

    // Write and read phases each run a two-state controller.
    typedef enum logic {
        PH_IDLE   = 1'b0,
        PH_ACTIVE = 1'b1
    } phase_t;

endpackage : mem_stage_transpose_pp_pkg
`default_nettype wire

// File: rtl/mem_stage_transpose_pp_lane_rotate.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_transpose_pp_lane_rotate
//  Purpose  : Combinational P-lane barrel rotator built from LOG_P stages.
//             Output lane k = input lane (k + i_amt) mod P.
//  Ports    : i_amt  - rotation amount (LOG_P bits)
//             i_data - P lanes of DATA_WIDTH bits, lane k at [k*DATA_WIDTH +:]
//             o_data - rotated lanes, same packing
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_transpose_pp_lane_rotate #(
    parameter int DATA_WIDTH = 8,
    parameter int P          = 4,
    parameter int LOG_P      = 2
) (
    input  logic [LOG_P-1:0]        i_amt,
    input  logic [P*DATA_WIDTH-1:0] i_data,
    output logic [P*DATA_WIDTH-1:0] o_data
);

    logic [LOG_P:0][P*DATA_WIDTH-1:0] w_stage;

    assign w_stage[0] = i_data;

    // Stage s rotates by 2^s when bit s of the amount is set; the stages
    // compose to a rotation by the full amount.
    for (genvar s = 0; s < LOG_P; s++) begin : g_stage
        for (genvar k = 0; k < P; k++) begin : g_lane
            assign w_stage[s+1][k*DATA_WIDTH +: DATA_WIDTH] =
                i_amt[s] ? w_stage[s][((k + (1 << s)) % P)*DATA_WIDTH +: DATA_WIDTH]
                         : w_stage[s][k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign o_data = w_stage[LOG_P];

endmodule : mem_stage_transpose_pp_lane_rotate
`default_nettype wire

// File: rtl/mem_stage_transpose_pp.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_transpose_pp
//  Purpose  : Streaming P x P block permutation stage. Mode 1 transposes each
//             block, mode 0 passes beats through. Ping-pong pages with
//             diagonal bank skew keep every bank to one write and one read
//             per cycle, so back-to-back blocks stream without bubbles.
//  Ports    : clk       - clock
//             rst       - synchronous active-low reset
//             in_start  - first beat of a block (P contiguous beats)
//             in_mode   - 1 transpose / 0 pass, sampled with in_start
//             in_data   - P lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//             out_data  - registered output beat, same packing
//             out_start - first output beat of a block
//             out_valid - P output beats per block
//             busy      - any phase or pipeline stage occupied
//             err       - sticky: in_start seen mid-block
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_transpose_pp
    import mem_stage_transpose_pp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int P          = 4,
    parameter int LOG_P      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_start,
    input  logic                    in_mode,
    input  logic [P*DATA_WIDTH-1:0] in_data,
    output logic [P*DATA_WIDTH-1:0] out_data,
    output logic                    out_start,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int               c_W    = P * DATA_WIDTH;
    localparam logic [LOG_P-1:0] c_LAST = LOG_P'(P - 1);

    // Write phase
    phase_t           r_wr_state;
    logic [LOG_P-1:0] r_wr_cnt;
    logic             r_wp;
    logic             r_wr_mode;
    // Read phase plus one pending block
    phase_t           r_rd_state;
    logic [LOG_P-1:0] r_rd_cnt;
    logic             r_rp;
    logic             r_rd_mode;
    logic             r_pend_valid;
    logic             r_pend_page;
    logic             r_pend_mode;
    // Pipeline: RAM output stage, then output register
    logic             r_q_valid;
    logic             r_q_start;
    logic [LOG_P-1:0] r_q_rot;
    logic [c_W-1:0]   r_out_data;
    logic             r_out_start;
    logic             r_out_valid;
    logic             r_err;

    logic             w_wr_active;
    logic             w_wr_en;
    logic [LOG_P-1:0] w_wr_t;
    logic             w_arm;
    logic             w_rd_active;
    logic [c_W-1:0]   w_wr_rot;
    logic [c_W-1:0]   w_q;
    logic [c_W-1:0]   w_rd_rot;

    assign w_wr_active = (r_wr_state == PH_ACTIVE);
    // The start beat is written in the same cycle it arrives, as beat 0.
    assign w_wr_en     = w_wr_active | in_start;
    assign w_wr_t      = w_wr_active ? r_wr_cnt : '0;
    assign w_arm       = w_wr_active && (r_wr_cnt == c_LAST);
    assign w_rd_active = (r_rd_state == PH_ACTIVE);

    // Lane c lands in bank (c+t): bank b takes lane (b-t), i.e. rotate by -t.
    mem_stage_transpose_pp_lane_rotate #(
        .DATA_WIDTH (DATA_WIDTH),
        .P          (P),
        .LOG_P      (LOG_P)
    ) u_wr_rot (
        .i_amt  (LOG_P'(0) - w_wr_t),
        .i_data (in_data),
        .o_data (w_wr_rot)
    );

    // Banks: each holds two pages of P words.
    for (genvar b = 0; b < P; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [2*P];
        logic [DATA_WIDTH-1:0] r_q_b;
        logic [LOG_P:0]        w_rd_addr;

        // Transpose walks the diagonal so that bank (r+k) yields beat k;
        // pass-through reads the same beat from every bank.
        assign w_rd_addr = (r_rd_mode == c_MODE_TRANSPOSE)
                         ? {r_rp, LOG_P'(b) - r_rd_cnt}
                         : {r_rp, r_rd_cnt};

        always_ff @(posedge clk) begin
            if (w_wr_en) begin
                r_mem[{r_wp, w_wr_t}] <= w_wr_rot[b*DATA_WIDTH +: DATA_WIDTH];
            end
            r_q_b <= r_mem[w_rd_addr];
        end

        assign w_q[b*DATA_WIDTH +: DATA_WIDTH] = r_q_b;
    end

    // Read rotator by r undoes the skew: out lane k = bank (k+r).
    mem_stage_transpose_pp_lane_rotate #(
        .DATA_WIDTH (DATA_WIDTH),
        .P          (P),
        .LOG_P      (LOG_P)
    ) u_rd_rot (
        .i_amt  (r_q_rot),
        .i_data (w_q),
        .o_data (w_rd_rot)
    );

    // Write phase controller
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_state <= PH_IDLE;
            r_wr_cnt   <= '0;
            r_wp       <= 1'b0;
            r_wr_mode  <= c_MODE_PASS;
            r_err      <= 1'b0;
        end else begin
            case (r_wr_state)
                PH_IDLE: begin
                    if (in_start) begin
                        r_wr_state <= PH_ACTIVE;
                        r_wr_cnt   <= LOG_P'(1);
                        r_wr_mode  <= in_mode;
                    end
                end
                default: begin
                    if (in_start) begin
                        r_err <= 1'b1;
                    end
                    r_wr_cnt <= r_wr_cnt + LOG_P'(1);
                    if (r_wr_cnt == c_LAST) begin
                        r_wr_state <= PH_IDLE;
                        r_wp       <= ~r_wp;
                    end
                end
            endcase
        end
    end

    // Read phase controller; a block armed while a read is mid-way waits in
    // the pending register and starts as soon as the current read ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_state   <= PH_IDLE;
            r_rd_cnt     <= '0;
            r_rp         <= 1'b0;
            r_rd_mode    <= c_MODE_PASS;
            r_pend_valid <= 1'b0;
            r_pend_page  <= 1'b0;
            r_pend_mode  <= c_MODE_PASS;
        end else begin
            case (r_rd_state)
                PH_IDLE: begin
                    if (w_arm) begin
                        r_rd_state <= PH_ACTIVE;
                        r_rd_cnt   <= '0;
                        r_rp       <= r_wp;
                        r_rd_mode  <= r_wr_mode;
                    end
                end
                default: begin
                    r_rd_cnt <= r_rd_cnt + LOG_P'(1);
                    if (r_rd_cnt == c_LAST) begin
                        if (r_pend_valid) begin
                            r_rp         <= r_pend_page;
                            r_rd_mode    <= r_pend_mode;
                            r_pend_valid <= w_arm;
                            r_pend_page  <= r_wp;
                            r_pend_mode  <= r_wr_mode;
                        end else if (w_arm) begin
                            r_rp      <= r_wp;
                            r_rd_mode <= r_wr_mode;
                        end else begin
                            r_rd_state <= PH_IDLE;
                        end
                    end else if (w_arm) begin
                        r_pend_valid <= 1'b1;
                        r_pend_page  <= r_wp;
                        r_pend_mode  <= r_wr_mode;
                    end
                end
            endcase
        end
    end

    // Output pipeline: RAM register, then rotated data register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q_valid   <= 1'b0;
            r_q_start   <= 1'b0;
            r_q_rot     <= '0;
            r_out_valid <= 1'b0;
            r_out_start <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_q_valid   <= w_rd_active;
            r_q_start   <= w_rd_active && (r_rd_cnt == '0);
            r_q_rot     <= r_rd_cnt;
            r_out_valid <= r_q_valid;
            r_out_start <= r_q_start;
            if (r_q_valid) begin
                r_out_data <= w_rd_rot;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_start = r_out_start;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign busy      = w_wr_active | w_rd_active | r_pend_valid | r_q_valid;

endmodule : mem_stage_transpose_pp
`default_nettype wire

// File: tb/tb_mem_stage_transpose_pp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_transpose_pp
//  Purpose  : Self-checking bench for mem_stage_transpose_pp (P=4, 8-bit).
//             Input beat t lane c carries base + 8'h{t,c}; per-cycle vector
//             tables hold stimulus and expected outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_transpose_pp;

    localparam int DW    = 8;
    localparam int P     = 4;
    localparam int LOG_P = 2;
    localparam int W     = P * DW;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_start;
    logic         in_mode;
    logic [W-1:0] in_data;
    logic [W-1:0] out_data;
    logic         out_start;
    logic         out_valid;
    logic         busy;
    logic         err;

    mem_stage_transpose_pp #(
        .DATA_WIDTH (DW),
        .P          (P),
        .LOG_P      (LOG_P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_start (out_start),
        .out_valid (out_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         st;
        logic         md;
        logic [W-1:0] din;
        logic         ev;
        logic         es;
        logic [W-1:0] ed;
    } vec_t;

    vec_t       tv [64];
    int         nv;
    // Block list for the current scenario
    int         nb;
    int         bs [4];
    logic       bm [4];
    logic [7:0] bb [4];
    int         stray;

    function automatic logic [W-1:0] in_beat(input int t, input logic [7:0] base);
        logic [W-1:0] v;
        for (int c = 0; c < P; c++) v[c*DW +: DW] = base + 8'(t*16 + c);
        return v;
    endfunction

    // Transposed beat r: lane k = input beat k, lane r.
    function automatic logic [W-1:0] tr_beat(input int r, input logic [7:0] base);
        logic [W-1:0] v;
        for (int k = 0; k < P; k++) v[k*DW +: DW] = base + 8'(k*16 + r);
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b0;
        in_start = 1'b0;
        in_mode  = 1'b0;
        in_data  = '0;
        tick();
        tick();
        rst = 1'b1;
        check({tag, " rst out_valid"}, W'(out_valid), '0);
        check({tag, " rst out_start"}, W'(out_start), '0);
        check({tag, " rst out_data"},  out_data,      '0);
        check({tag, " rst busy"},      W'(busy),      '0);
        check({tag, " rst err"},       W'(err),       '0);
    endtask

    // Expand the block list into a per-cycle table. Non-start beats carry
    // the opposite mode and idle cycles carry junk data, both must be ignored.
    task automatic build();
        logic [W-1:0] hold;
        int           last;
        hold = '0;
        last = 0;
        for (int b = 0; b < nb; b++) if (bs[b] > last) last = bs[b];
        nv = last + 2*P + 3;
        for (int c = 0; c < nv; c++) begin
            tv[c].st  = 1'b0;
            tv[c].md  = c[0];
            tv[c].din = 32'hA5A5_5A5A ^ W'(c);
            tv[c].ev  = 1'b0;
            tv[c].es  = 1'b0;
            for (int b = 0; b < nb; b++) begin
                if (c >= bs[b] && c < bs[b] + P) begin
                    tv[c].st  = (c == bs[b]);
                    tv[c].md  = (c == bs[b]) ? bm[b] : ~bm[b];
                    tv[c].din = in_beat(c - bs[b], bb[b]);
                end
                if (c >= bs[b] + P + 2 && c < bs[b] + 2*P + 2) begin
                    tv[c].ev = 1'b1;
                    tv[c].es = (c == bs[b] + P + 2);
                    hold = bm[b] ? tr_beat(c - bs[b] - P - 2, bb[b])
                                 : in_beat(c - bs[b] - P - 2, bb[b]);
                end
            end
            tv[c].ed = hold;
            if (c == stray) tv[c].st = 1'b1;
        end
    endtask

    task automatic run_table(input string tag);
        for (int c = 0; c < nv; c++) begin
            in_start = tv[c].st;
            in_mode  = tv[c].md;
            in_data  = tv[c].din;
            check($sformatf("%s c%0d out_valid", tag, c), W'(out_valid), W'(tv[c].ev));
            check($sformatf("%s c%0d out_start", tag, c), W'(out_start), W'(tv[c].es));
            check($sformatf("%s c%0d out_data",  tag, c), out_data,      tv[c].ed);
            if (c == bs[0] + 1)
                check($sformatf("%s c%0d busy", tag, c), W'(busy), W'(1));
            tick();
        end
        in_start = 1'b0;
        check({tag, " idle busy"}, W'(busy), '0);
    endtask

    initial begin
        rst      = 1'b0;
        in_start = 1'b0;
        in_mode  = 1'b0;
        in_data  = '0;
        stray    = -1;

        // 1: single transpose block
        do_reset("t1");
        nb = 1; bs[0] = 0; bm[0] = 1'b1; bb[0] = 8'h00; stray = -1;
        build();
        run_table("t1");
        check("t1 err", W'(err), '0);

        // 2: single pass-through block
        do_reset("t2");
        nb = 1; bs[0] = 0; bm[0] = 1'b0; bb[0] = 8'h00; stray = -1;
        build();
        run_table("t2");

        // 3: three back-to-back blocks, modes 1,0,1
        do_reset("t3");
        nb = 3;
        bs[0] = 0; bm[0] = 1'b1; bb[0] = 8'h00;
        bs[1] = 4; bm[1] = 1'b0; bb[1] = 8'h40;
        bs[2] = 8; bm[2] = 1'b1; bb[2] = 8'h00;
        stray = -1;
        build();
        run_table("t3");
        check("t3 err", W'(err), '0);

        // 4: stray in_start at cycle 2 is ignored but flags err
        do_reset("t4");
        nb = 1; bs[0] = 0; bm[0] = 1'b1; bb[0] = 8'h00; stray = 2;
        build();
        run_table("t4");
        check("t4 err sticky", W'(err), W'(1));

        // 6: three idle cycles between blocks; output holds last beat
        do_reset("t6");
        nb = 2;
        bs[0] = 0; bm[0] = 1'b1; bb[0] = 8'h00;
        bs[1] = 7; bm[1] = 1'b0; bb[1] = 8'h40;
        stray = -1;
        build();
        run_table("t6");

        // 5: reset at cycle 5 of a transpose block (err set first by a stray)
        do_reset("t5");
        for (int c = 0; c < 6; c++) begin
            in_start = (c == 0) || (c == 1);
            in_mode  = 1'b1;
            in_data  = (c < P) ? in_beat(c, 8'h00) : '0;
            if (c == 5) begin
                check("t5 err before reset", W'(err), W'(1));
                rst = 1'b0;
            end
            tick();
        end
        in_start = 1'b0;
        check("t5 post-rst out_valid", W'(out_valid), '0);
        check("t5 post-rst out_start", W'(out_start), '0);
        check("t5 post-rst busy",      W'(busy),      '0);
        check("t5 post-rst err",       W'(err),       '0);
        check("t5 post-rst out_data",  out_data,      '0);
        rst = 1'b1;
        nb = 1; bs[0] = 0; bm[0] = 1'b1; bb[0] = 8'h80; stray = -1;
        build();
        run_table("t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_stage_transpose_pp
`default_nettype wire
